// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and encodings for the hazard scoreboard: Tuse/Tnew codes
// and multiply/divide operation codes.
package hazard_scoreboard_pkg;

    localparam int TUSE_D    = 0;
    localparam int TUSE_E    = 1;
    localparam int TUSE_M    = 2;
    localparam int TUSE_NONE = 3;

    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LOAD = 2;
    localparam int TNEW_LINK = 0;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_RSVD = 2'b11
    } md_op_e;

    // Scoreboard entry at the default widths (REG_W = 5, T_W = 2).
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        md_op_e     md_op;
    } sb_entry_t;

endpackage

// File: rtl/hazard_operand_check.sv
// Youngest-match operand hazard test for one source register against the
// E/M/W scoreboard destinations.
module hazard_operand_check #(
    parameter int REG_W = 5,
    parameter int T_W   = 2
) (
    input  logic             valid,
    input  logic [REG_W-1:0] src,
    input  logic [T_W-1:0]   tuse,
    input  logic [REG_W-1:0] e_dst,
    input  logic [T_W-1:0]   e_tnew,
    input  logic [REG_W-1:0] m_dst,
    input  logic [T_W-1:0]   m_tnew,
    input  logic [REG_W-1:0] w_dst,
    output logic             hazard
);

    // A younger match shadows older ones; a W match is always ready.
    always_comb begin
        hazard = 1'b0;
        if (valid && (src != '0) && (tuse != '1)) begin
            if (src == e_dst)
                hazard = (e_tnew > tuse);
            else if (src == m_dst)
                hazard = (m_tnew > tuse);
            else if (src == w_dst)
                hazard = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline stall unit: per-stage destination/Tnew scoreboard for E, M and W
// plus a busy counter for the multi-cycle multiply/divide unit.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int T_W         = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic [T_W-1:0]   d_tuse_rs,
    input  logic [T_W-1:0]   d_tuse_rt,
    input  logic [REG_W-1:0] d_dst,
    input  logic [T_W-1:0]   d_tnew,
    input  logic [1:0]       d_md_op,
    input  logic             d_hilo_use,
    output logic             pc_en,
    output logic             d_en,
    output logic             e_flush,
    output logic             stall,
    output logic [REG_W-1:0] e_dst,
    output logic [REG_W-1:0] m_dst,
    output logic [REG_W-1:0] w_dst,
    output logic [T_W-1:0]   e_tnew,
    output logic [T_W-1:0]   m_tnew,
    output logic             md_start,
    output logic             md_busy
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic [T_W-1:0]   tnew;
        md_op_e           md_op;
    } entry_t;

    entry_t           e_entry;
    logic [CNT_W-1:0] cnt;
    md_op_e           d_md;
    logic             rs_hazard;
    logic             rt_hazard;
    logic             hilo_hazard;

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

    assign d_md = (d_md_op == MD_RSVD) ? MD_NONE : md_op_e'(d_md_op);

    hazard_operand_check #(.REG_W(REG_W), .T_W(T_W)) u_rs_check (
        .valid  (d_valid),
        .src    (d_rs),
        .tuse   (d_tuse_rs),
        .e_dst  (e_entry.dst),
        .e_tnew (e_entry.tnew),
        .m_dst  (m_dst),
        .m_tnew (m_tnew),
        .w_dst  (w_dst),
        .hazard (rs_hazard)
    );

    hazard_operand_check #(.REG_W(REG_W), .T_W(T_W)) u_rt_check (
        .valid  (d_valid),
        .src    (d_rt),
        .tuse   (d_tuse_rt),
        .e_dst  (e_entry.dst),
        .e_tnew (e_entry.tnew),
        .m_dst  (m_dst),
        .m_tnew (m_tnew),
        .w_dst  (w_dst),
        .hazard (rt_hazard)
    );

    assign md_start    = (e_entry.md_op != MD_NONE);
    assign md_busy     = (cnt != '0);
    assign hilo_hazard = d_valid && (d_hilo_use || (d_md != MD_NONE)) && (md_busy || md_start);

    assign stall   = rs_hazard | rt_hazard | hilo_hazard;
    assign pc_en   = !stall;
    assign d_en    = !stall;
    assign e_flush = stall;
    assign e_dst   = e_entry.dst;
    assign e_tnew  = e_entry.tnew;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_entry <= '0;
            m_dst   <= '0;
            m_tnew  <= '0;
            w_dst   <= '0;
            cnt     <= '0;
        end else begin
            if (d_valid && !stall) begin
                e_entry.dst   <= d_dst;
                e_entry.tnew  <= d_tnew;
                e_entry.md_op <= d_md;
            end else begin
                e_entry <= '0;
            end
            m_dst  <= e_entry.dst;
            m_tnew <= sat_dec(e_entry.tnew);
            w_dst  <= m_dst;
            // A new mult/div in E always reloads, even over a running count.
            case (e_entry.md_op)
                MD_MULT: cnt <= CNT_W'(MULT_CYCLES);
                MD_DIV:  cnt <= CNT_W'(DIV_CYCLES);
                default: if (cnt != '0) cnt <= cnt - CNT_W'(1);
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_op;
    logic       d_hilo_use;
    logic       pc_en, d_en, e_flush, stall, md_start, md_busy;
    logic [4:0] e_dst, m_dst, w_dst;
    logic [1:0] e_tnew, m_tnew;

    hazard_scoreboard #(
        .REG_W(5), .T_W(2), .MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_md_op(d_md_op), .d_hilo_use(d_hilo_use),
        .pc_en(pc_en), .d_en(d_en), .e_flush(e_flush), .stall(stall),
        .e_dst(e_dst), .m_dst(m_dst), .w_dst(w_dst),
        .e_tnew(e_tnew), .m_tnew(m_tnew), .md_start(md_start), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: what entered E at each of the last three cycles,
    // with its Tnew as issued, plus the cycle window in which HI/LO is busy.
    int sb_dst[3];
    int sb_tn[3];
    int e_md;
    bit md_act;
    int md_t, md_lat;
    int cyc;
    bit exp_stall;

    bit last_stall, last_busy;
    int last_e_dst, last_e_tnew, last_m_dst;
    int n_st, n_busy;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rem(input int k);
        if (k == 2) return 0;
        return (sb_tn[k] - k < 0) ? 0 : sb_tn[k] - k;
    endfunction

    function automatic bit op_haz(input bit v, input int r, input int tu);
        if (!v || r == 0 || tu == TUSE_NONE) return 1'b0;
        for (int k = 0; k < 3; k++)
            if (sb_dst[k] == r) return rem(k) > tu;
        return 1'b0;
    endfunction

    function automatic int md_norm(input int m);
        return (m == 3) ? 0 : m;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            sb_dst[k] = 0;
            sb_tn[k]  = 0;
        end
        e_md   = 0;
        md_act = 1'b0;
    endtask

    task automatic step();
        bit busy_e, start_e;
        @(negedge clk);
        start_e   = (e_md != 0);
        busy_e    = md_act && (cyc > md_t) && (cyc <= md_t + md_lat);
        exp_stall = op_haz(d_valid, int'(d_rs), int'(d_tuse_rs))
                  | op_haz(d_valid, int'(d_rt), int'(d_tuse_rt))
                  | (d_valid && (d_hilo_use || md_norm(int'(d_md_op)) != 0) && (start_e || busy_e));
        chk("stall",    int'(stall),    int'(exp_stall));
        chk("pc_en",    int'(pc_en),    int'(!exp_stall));
        chk("d_en",     int'(d_en),     int'(!exp_stall));
        chk("e_flush",  int'(e_flush),  int'(exp_stall));
        chk("e_dst",    int'(e_dst),    sb_dst[0]);
        chk("m_dst",    int'(m_dst),    sb_dst[1]);
        chk("w_dst",    int'(w_dst),    sb_dst[2]);
        chk("e_tnew",   int'(e_tnew),   rem(0));
        chk("m_tnew",   int'(m_tnew),   rem(1));
        chk("md_start", int'(md_start), int'(start_e));
        chk("md_busy",  int'(md_busy),  int'(busy_e));
        last_stall  = stall;
        last_busy   = md_busy;
        last_e_dst  = int'(e_dst);
        last_e_tnew = int'(e_tnew);
        last_m_dst  = int'(m_dst);
        @(posedge clk);
        if (!reset_n) begin
            model_clear();
        end else begin
            sb_dst[2] = sb_dst[1]; sb_tn[2] = sb_tn[1];
            sb_dst[1] = sb_dst[0]; sb_tn[1] = sb_tn[0];
            if (d_valid && !exp_stall) begin
                sb_dst[0] = int'(d_dst);
                sb_tn[0]  = int'(d_tnew);
                e_md      = md_norm(int'(d_md_op));
            end else begin
                sb_dst[0] = 0;
                sb_tn[0]  = 0;
                e_md      = 0;
            end
            if (e_md != 0) begin
                md_act = 1'b1;
                md_t   = cyc + 1;
                md_lat = (e_md == 1) ? MULT_LAT : DIV_LAT;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_d(input bit v, input int rs, input int tu_rs, input int rt, input int tu_rt,
                         input int dst, input int tn, input int md, input bit hilo);
        d_valid    = v;
        d_rs       = 5'(rs);
        d_tuse_rs  = 2'(tu_rs);
        d_rt       = 5'(rt);
        d_tuse_rt  = 2'(tu_rt);
        d_dst      = 5'(dst);
        d_tnew     = 2'(tn);
        d_md_op    = 2'(md);
        d_hilo_use = hilo;
    endtask

    task automatic nop();
        set_d(1'b0, 0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 0, 1'b0);
    endtask

    // Holds an instruction in D until accepted; counts stall and busy cycles.
    task automatic issue(input int rs, input int tu_rs, input int rt, input int tu_rt,
                         input int dst, input int tn, input int md, input bit hilo);
        bool_accept: begin
            bit done;
            done = 1'b0;
            n_st = 0; n_busy = 0;
            set_d(1'b1, rs, tu_rs, rt, tu_rt, dst, tn, md, hilo);
            for (int i = 0; i < 40 && !done; i++) begin
                step();
                if (last_busy) n_busy++;
                if (last_stall) n_st++;
                else done = 1'b1;
            end
            if (!done) chk("issue_timeout", 0, 1);
        end
        nop();
    endtask

    task automatic drain(input int n);
        nop();
        repeat (n) step();
    endtask

    initial begin
        model_clear();
        cyc = 0;
        md_t = 0; md_lat = 0;
        reset_n = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        step();
        reset_n = 1'b1;
        step();
        chk("reset_stall", int'(last_stall), 0);
        chk("reset_e_dst", last_e_dst, 0);
        chk("reset_busy", int'(last_busy), 0);

        // lw $1 ; addu $3,$1,$2
        issue(0, TUSE_NONE, 0, TUSE_NONE, 1, TNEW_LOAD, 0, 0);
        chk("lw_no_stall", n_st, 0);
        issue(1, TUSE_E, 2, TUSE_E, 3, TNEW_ALU, 0, 0);
        chk("lw_addu_stalls", n_st, 1);
        step();
        chk("addu_in_e_dst", last_e_dst, 3);
        chk("addu_in_e_tnew", last_e_tnew, 1);
        drain(3);

        // lw $1 ; beq $1,$2
        issue(0, TUSE_NONE, 0, TUSE_NONE, 1, TNEW_LOAD, 0, 0);
        issue(1, TUSE_D, 2, TUSE_D, 0, 0, 0, 0);
        chk("lw_beq_stalls", n_st, 2);
        drain(3);

        // addu $1 ; beq $1
        issue(0, TUSE_NONE, 0, TUSE_NONE, 1, TNEW_ALU, 0, 0);
        issue(1, TUSE_D, 0, TUSE_NONE, 0, 0, 0, 0);
        chk("addu_beq_stalls", n_st, 1);
        drain(3);

        // addu $1 ; sw $1 as rt
        issue(0, TUSE_NONE, 0, TUSE_NONE, 1, TNEW_ALU, 0, 0);
        issue(2, TUSE_E, 1, TUSE_M, 0, 0, 0, 0);
        chk("addu_sw_stalls", n_st, 0);
        drain(3);

        // lw $0 ; addu $3,$0,$0
        issue(0, TUSE_NONE, 0, TUSE_NONE, 0, TNEW_LOAD, 0, 0);
        issue(0, TUSE_E, 0, TUSE_E, 3, TNEW_ALU, 0, 0);
        chk("reg0_stalls", n_st, 0);
        drain(3);

        // Shadowing: lw $5 in M, addu $5 in E, reader tuse 1
        issue(0, TUSE_NONE, 0, TUSE_NONE, 5, TNEW_LOAD, 0, 0);
        issue(0, TUSE_NONE, 0, TUSE_NONE, 5, TNEW_ALU, 0, 0);
        issue(5, TUSE_E, 0, TUSE_NONE, 6, TNEW_ALU, 0, 0);
        chk("shadow_alu_stalls", n_st, 0);
        drain(3);

        // Shadowing by jal-like tnew 0 over a load in M, reader tuse 0
        issue(0, TUSE_NONE, 0, TUSE_NONE, 5, TNEW_LOAD, 0, 0);
        issue(0, TUSE_NONE, 0, TUSE_NONE, 5, TNEW_LINK, 0, 0);
        issue(5, TUSE_D, 0, TUSE_NONE, 0, 0, 0, 0);
        chk("shadow_link_stalls", n_st, 0);
        drain(3);

        // mult ; mfhi
        issue(1, TUSE_E, 2, TUSE_E, 0, 0, MD_MULT, 0);
        issue(0, TUSE_NONE, 0, TUSE_NONE, 3, TNEW_ALU, 0, 1);
        chk("mult_mfhi_stalls", n_st, 6);
        chk("mult_busy_cycles", n_busy, MULT_LAT);
        step();
        chk("mfhi_in_e", last_e_dst, 3);
        drain(2);

        // div ; mfhi
        issue(1, TUSE_E, 2, TUSE_E, 0, 0, MD_DIV, 0);
        issue(0, TUSE_NONE, 0, TUSE_NONE, 4, TNEW_ALU, 0, 1);
        chk("div_mfhi_stalls", n_st, 11);
        chk("div_busy_cycles", n_busy, DIV_LAT);
        drain(3);

        // Reset while a div is counting (cnt = 7)
        issue(1, TUSE_E, 2, TUSE_E, 0, 0, MD_DIV, 0);
        repeat (4) step();
        set_d(1'b1, 0, TUSE_NONE, 0, TUSE_NONE, 3, TNEW_ALU, 0, 1'b1);
        reset_n = 1'b0;
        step();
        chk("pre_reset_busy", int'(last_busy), 1);
        reset_n = 1'b1;
        step();
        chk("post_reset_busy", int'(last_busy), 0);
        chk("post_reset_stall", int'(last_stall), 0);
        chk("post_reset_e_dst", last_e_dst, 0);
        drain(3);

        // Reset during a pending load-use stall
        issue(0, TUSE_NONE, 0, TUSE_NONE, 1, TNEW_LOAD, 0, 0);
        set_d(1'b1, 1, TUSE_E, 0, TUSE_NONE, 3, TNEW_ALU, 0, 1'b0);
        reset_n = 1'b0;
        step();
        chk("load_stall_before_reset", int'(last_stall), 1);
        reset_n = 1'b1;
        step();
        chk("load_stall_after_reset", int'(last_stall), 0);
        chk("load_reset_m_dst", last_m_dst, 0);
        drain(3);

        // d_valid = 0 with matching rs
        issue(0, TUSE_NONE, 0, TUSE_NONE, 1, TNEW_LOAD, 0, 0);
        set_d(1'b0, 1, TUSE_D, 1, TUSE_D, 7, TNEW_ALU, 0, 1'b0);
        step();
        chk("invalid_no_stall", int'(last_stall), 0);
        nop();
        step();
        chk("invalid_bubble_e", last_e_dst, 0);
        drain(3);

        // Randomized traffic, D held stable while stalled
        for (int i = 0; i < 3000; i++) begin
            if (!exp_stall) begin
                int md_r;
                md_r = $urandom_range(0, 19);
                set_d(($urandom_range(0, 5) != 0),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      (md_r < 3) ? md_r + 1 : 0,
                      ($urandom_range(0, 7) == 0));
            end
            reset_n = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1'b1;
        drain(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
